// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side types, command bytes and frame helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_SEND,
        ST_ACK,
        ST_WAITIDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_SETRATE = 8'hF3;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Bit driven after the (idx+1)-th device falling edge: d0..d7, parity, stop.
    function automatic logic ps2_frame_bit(input logic [7:0] d, input logic [3:0] idx);
        logic b;
        if (idx < 4'd8) begin
            b = d[idx[2:0]];
        end else if (idx == 4'd8) begin
            b = ps2_odd_parity(d);
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock/data pads plus clock falling-edge strobe.
// Edge strobe lags the pad by 2-3 cycles; levels reset to the idle-high bus state.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_clk_pad,
    input  logic i_dat_pad,
    output logic o_clk_lvl,
    output logic o_dat_lvl,
    output logic o_clk_fe
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_clk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_clk_pad};
            r_dat_sync <= {r_dat_sync[0], i_dat_pad};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign o_clk_lvl = r_clk_sync[1];
    assign o_dat_lvl = r_dat_sync[1];
    assign o_clk_fe  = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (request-to-send, 11-bit frame, ack check, timeout).
// Accepts one start per idle period, ignores start while busy; board top wraps pads with IOBUF I=0, T=~oe.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       msclk_i,
    input  logic       msdat_i,
    output logic       msclk_oe,
    output logic       msdat_oe
);

    import ps2_pkg::*;

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_DAT  = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic w_clk_lvl;
    logic w_dat_lvl;
    logic w_fe;

    ps2_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_clk_pad (msclk_i),
        .i_dat_pad (msdat_i),
        .o_clk_lvl (w_clk_lvl),
        .o_dat_lvl (w_dat_lvl),
        .o_clk_fe  (w_fe)
    );

    ps2_state_t    r_state,  w_state_nxt;
    logic [CW-1:0] r_cnt,    w_cnt_nxt;
    logic [3:0]    r_bit,    w_bit_nxt;
    logic [7:0]    r_data,   w_data_nxt;
    logic          r_nack,   w_nack_nxt;
    logic          r_clk_oe, w_clk_oe_nxt;
    logic          r_dat_oe, w_dat_oe_nxt;
    logic          r_done,   w_done_nxt;
    logic          r_err,    w_err_nxt;
    logic          r_ready;
    logic          w_timed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_data   <= '0;
            r_nack   <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_data   <= w_data_nxt;
            r_nack   <= w_nack_nxt;
            r_clk_oe <= w_clk_oe_nxt;
            r_dat_oe <= w_dat_oe_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_ready  <= (w_state_nxt == ST_IDLE);
        end
    end

    assign w_timed = (r_state == ST_SEND || r_state == ST_ACK || r_state == ST_WAITIDLE)
                     && (r_cnt == TMO_LAST) && !w_fe;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_data_nxt   = r_data;
        w_nack_nxt   = r_nack;
        w_clk_oe_nxt = r_clk_oe;
        w_dat_oe_nxt = r_dat_oe;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_cnt_nxt    = '0;
                if (start) begin
                    w_state_nxt  = ST_INHIBIT;
                    w_data_nxt   = data;
                    w_bit_nxt    = '0;
                    w_nack_nxt   = 1'b0;
                    w_clk_oe_nxt = 1'b1;
                    w_dat_oe_nxt = (INHIBIT_CYCLES == 1);
                end
            end
            ST_INHIBIT: begin
                w_clk_oe_nxt = 1'b1;
                w_cnt_nxt    = r_cnt + 1'b1;
                // Start bit goes out together with the final clock-low cycle.
                w_dat_oe_nxt = (r_cnt == INH_DAT);
                if (r_cnt == INH_LAST) begin
                    w_state_nxt  = ST_SEND;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end
            end
            ST_SEND: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_fe) begin
                    w_cnt_nxt    = '0;
                    w_dat_oe_nxt = ~ps2_frame_bit(r_data, r_bit);
                    w_bit_nxt    = r_bit + 4'd1;
                    if (r_bit == 4'd9) begin
                        w_state_nxt = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_fe) begin
                    w_cnt_nxt   = '0;
                    w_nack_nxt  = w_dat_lvl;
                    w_state_nxt = ST_WAITIDLE;
                end
            end
            ST_WAITIDLE: begin
                w_cnt_nxt = w_fe ? '0 : r_cnt + 1'b1;
                if (w_clk_lvl && w_dat_lvl) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = r_nack;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
            end
        endcase

        // A silent device must never leave the bus pulled low.
        if (w_timed) begin
            w_state_nxt  = ST_IDLE;
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_done_nxt   = 1'b1;
            w_err_nxt    = 1'b1;
        end
    end

    assign ready    = r_ready;
    assign busy     = ~r_ready;
    assign done     = r_done;
    assign err      = r_err;
    assign msclk_oe = r_clk_oe;
    assign msdat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model plus a PS/2 device model clocking at a scaled rate.
module tb_ps2_host_tx;

    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       start = 1'b0;
    logic       ready, busy, done, err;
    logic       msclk_oe, msdat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       msclk_pad, msdat_pad;

    assign msclk_pad = dev_clk & ~msclk_oe;
    assign msdat_pad = dev_dat & ~msdat_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .start    (start),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .msclk_i  (msclk_pad),
        .msdat_i  (msdat_pad),
        .msclk_oe (msclk_oe),
        .msdat_oe (msdat_oe)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    int   done_cnt = 0;
    int   dbl_cnt = 0;
    logic last_err = 1'b0;
    logic last_oe_clr = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            last_err = err;
            last_oe_clr = !msclk_oe && !msdat_oe;
            if (prev_done === 1'b1) dbl_cnt++;
        end
        prev_done = done;
    end

    // Device side: waits for request-to-send, samples each host bit late in the
    // clock-low phase, and drives the ack bit before the 11th falling edge.
    task automatic dev_run(input int n_edges, input bit ack, output logic [10:0] got, output bit ok);
        int w1, w2;
        got = '1;
        ok  = 1'b1;
        w1 = 0;
        while (msclk_oe !== 1'b1 && w1 < 100) begin @(negedge clk); w1++; end
        w2 = 0;
        while (msclk_oe !== 1'b0 && w2 < 100) begin @(negedge clk); w2++; end
        if (w1 >= 100 || w2 >= 100) begin
            ok = 1'b0;
            return;
        end
        repeat (10) @(negedge clk);
        got[0] = msdat_pad;
        for (int i = 1; i <= n_edges; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i <= 10) got[4'(i)] = msdat_pad;
            dev_clk = 1'b1;
            if (i == 10 && n_edges == 11) begin
                repeat (HALF / 2) @(negedge clk);
                dev_dat = ~ack;
                repeat (HALF / 2) @(negedge clk);
            end else begin
                if (i == 11) dev_dat = 1'b1;
                repeat (HALF) @(negedge clk);
            end
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  d;
        bit          ack;
        bit          inject;
        logic [10:0] exp_frame;   // {stop, parity, d7..d0, start}
        bit          exp_err;
    } vec_t;

    vec_t        vecs[5];
    logic [10:0] got;
    bit          ok;
    int          base, w, done_k, send_k, clk_hi, dat_first;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hF4, 1'b1, 1'b1, 11'b1_0_11110100_0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 11'b1_1_00000000_0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 11'b1_1_11111111_0, 1'b0};
        vecs[3] = '{8'hF3, 1'b1, 1'b0, 11'b1_1_11110011_0, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 11'b1_0_00000001_0, 1'b1};

        repeat (4) @(negedge clk);
        chk("reset_msclk_oe", msclk_oe, 0);
        chk("reset_msdat_oe", msdat_oe, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            base = done_cnt;
            data = vecs[i].d;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (vecs[i].inject) begin
                data = ~vecs[i].d;
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            dev_run(11, vecs[i].ack, got, ok);
            chk($sformatf("handshake%0d", i), ok, 1);
            chk($sformatf("frame%0d", i), got, vecs[i].exp_frame);
            w = 0;
            while (done_cnt == base && w < 300) begin @(negedge clk); w++; end
            chk($sformatf("done_count%0d", i), done_cnt - base, 1);
            chk($sformatf("done_err%0d", i), last_err, vecs[i].exp_err);
            chk($sformatf("done_oe_clear%0d", i), last_oe_clr, 1);
            @(negedge clk);
            chk($sformatf("ready_after_done%0d", i), ready, 1);
            repeat (5) @(negedge clk);
        end

        // Inhibit length, start-bit timing and timeout with a silent device.
        base = done_cnt;
        data = 8'hF3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_k = 0; send_k = 0; clk_hi = 0; dat_first = 0;
        for (int k = 1; k <= 400; k++) begin
            if (k == 1) begin
                chk("busy_after_start", busy, 1);
                chk("ready_after_start", ready, 0);
            end
            if (msclk_oe) clk_hi++;
            if (msdat_oe && dat_first == 0) dat_first = k;
            if (!msclk_oe && send_k == 0) send_k = k;
            if (done) begin
                done_k = k;
                chk("timeout_err", err, 1);
                chk("timeout_oe", {msclk_oe, msdat_oe}, 0);
                break;
            end
            @(negedge clk);
        end
        chk("inhibit_clk_cycles", clk_hi, 16);
        chk("inhibit_dat_rise", dat_first, 16);
        chk("send_entry", send_k, 17);
        chk("timeout_cycle", done_k, 117);
        @(negedge clk);
        chk("timeout_ready", ready, 1);
        chk("timeout_single_done", done_cnt - base, 1);
        repeat (5) @(negedge clk);

        // Reset in the middle of a frame, after the 4th device falling edge.
        data = 8'hF3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dev_run(4, 1'b1, got, ok);
        chk("rst_handshake", ok, 1);
        chk("rst_pre_bits", got[4:0], 5'b00110);
        chk("rst_pre_dat_oe", msdat_oe, 1);
        base = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_oe_clear", {msclk_oe, msdat_oe}, 0);
        chk("rst_ready", ready, 1);
        repeat (150) @(negedge clk);
        chk("rst_no_done", done_cnt - base, 0);
        chk("done_one_cycle", dbl_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. Sends one command byte (reset 0xFF, enable reporting 0xF4, set sample rate 0xF3 plus argument, and so on) to a mouse or keyboard using the PS/2 request-to-send sequence, then checks the device's acknowledge bit. It shares the open-drain `msclk`/`msdat` pads with the PS/2 mouse receiver. `busy` tells the top level to hold the receiver off while a frame is in flight.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 2500: clock-low request time (100 µs at 25 MHz).
- `TIMEOUT_CYCLES`, default 375000: maximum gap between device clock falling edges, and maximum wait for idle (15 ms at 25 MHz).

Ports:
- `clk` in 1: the single system clock.
- `rst` in 1: synchronous, active-high reset.
- `data` in 8: byte to send; latched when a start is accepted.
- `start` in 1: request; accepted only in a cycle where `ready`=1.
- `ready` out 1: 1 in IDLE only.
- `busy` out 1: equals `~ready`.
- `done` out 1: one-cycle pulse when a transfer ends.
- `err` out 1: valid with `done`; 1 = NACK or timeout.
- `msclk_i` in 1: raw clock pad input (asynchronous).
- `msdat_i` in 1: raw data pad input (asynchronous).
- `msclk_oe` out 1: 1 = drive clock pad low; 0 = release.
- `msdat_oe` out 1: 1 = drive data pad low; 0 = release.

## Operation
- Pad inputs pass through a 2-flop synchronizer. A falling edge `fe` = previous synced sample 1 and current sample 0.
- Frame on the wire:
  - start bit 0
  - `d[0]`…`d[7]`, LSB first
  - odd parity `~^d`
  - stop bit 1
  - device ack (0 = ACK)
- The host drives a 0 by setting `oe`=1 and a 1 by setting `oe`=0.
- States:
  - IDLE: both `oe`=0. On `start`: latch `data`, go to INHIBIT.
  - INHIBIT: `msclk_oe`=1 for exactly `INHIBIT_CYCLES` cycles. In the last cycle also set `msdat_oe`=1 (start bit). Then go to SEND.
  - SEND: `msclk_oe`=0; `msdat_oe` holds the current bit.
    - Each `fe` advances the bit index 0..9 through d0..d7, parity, stop; the host changes data after the falling edge.
    - On the 10th `fe`, output the stop bit (`msdat_oe`=0) and go to ACK.
  - ACK: wait for the 11th `fe`. Sample synced data at that edge: 0 → ACK, 1 → NACK. Go to WAITIDLE.
  - WAITIDLE: wait until synced clock and data are both 1. Then pulse `done` with `err` = NACK, and return to IDLE.
- Timeout: a counter is cleared on every `fe` and on each state entry, and counts in SEND, ACK and WAITIDLE. When it reaches `TIMEOUT_CYCLES`, both `oe` go to 0, `done`=1, `err`=1, and the state returns to IDLE.
- `start` while busy is ignored; it is neither queued nor latched.
- `rst` mid-transfer: next cycle `msclk_oe`=`msdat_oe`=0, state IDLE, `done`=0, no pulse emitted.

## Timing
- Reset values:
  - `msclk_oe`=0, `msdat_oe`=0
  - `done`=0, `err`=0
  - `ready`=1, `busy`=0
  - state IDLE, counters 0
- `start`&`ready` at cycle T: `ready`=0 and `msclk_oe`=1 from T+1.
- `msclk_oe` stays 1 for cycles T+1…T+`INHIBIT_CYCLES`. `msdat_oe`=1 from T+`INHIBIT_CYCLES`, and `msclk_oe`=0 from T+`INHIBIT_CYCLES`+1.
- Pad falling edge to `fe`: 2–3 `clk` cycles. `msdat_oe` updates the cycle after `fe`.
- `done`/`err` last exactly one cycle. `ready`=1 in the cycle after `done`, so a new `start` may be accepted there.
- All outputs are registered. No combinational path from pad inputs to `oe`.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, SEND, ACK, WAITIDLE)
  - command constants `PS2_CMD_RESET`=8'hFF, `PS2_CMD_ENABLE`=8'hF4, `PS2_CMD_SETRATE`=8'hF3, `PS2_ACK`=8'hFA
  - odd-parity function
- Sub-module `ps2_sync_edge` provides the 2-flop synchronizer, falling-edge detect and synced level outputs. It is reused by the receiver.
- IOBUF instantiation stays at the top level: `I`=0, `T`=`~oe`.

## Test plan
- Send 0xF4 to a device model that clocks at 12.5 kHz and ACKs.
  - Required: data bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Required: `done` pulses once with `err`=0.
- Send 0x00 → parity bit 1, and `msdat_oe`=1 for all 8 data bits. Then 0xFF → parity 1, `msdat_oe`=0 for all data bits.
- Inhibit check: `INHIBIT_CYCLES`=16.
  - `msclk_oe` must be high for exactly 16 cycles.
  - `msdat_oe` must rise in the 16th cycle.
- NACK: the model leaves data high at the 11th edge → `done` with `err`=1, both `oe`=0.
- Timeout: `TIMEOUT_CYCLES`=100 and the device never clocks → `done`/`err`=1 exactly 100 cycles after SEND entry, then `ready`=1.
- `rst` after the 4th `fe` → both `oe`=0 next cycle, no `done`. Also: a `start` pulse during busy does not change the transmitted byte.
